// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush
// sequencer. The master side is the pipeline: it reports hazard sources and
// consumes the stall/flush enables. The slave side is pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if;
  logic       idex_mem_read;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       exmem_pc_src;
  logic       dmem_req;
  logic       dmem_ready;
  logic       imem_ready;

  logic       stall_pc;
  logic       stall_ifid;
  logic       stall_idex;
  logic       stall_exmem;
  logic       flush_ifid;
  logic       flush_idex;
  logic       flush_exmem;
  logic       flush_memwb;
  logic [1:0] ctrl_state;
  logic       mem_timeout;

  modport master (
    output idex_mem_read, idex_rt, ifid_rs, ifid_rt,
           exmem_pc_src, dmem_req, dmem_ready, imem_ready,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem,
           flush_ifid, flush_idex, flush_exmem, flush_memwb,
           ctrl_state, mem_timeout
  );

  modport slave (
    input  idex_mem_read, idex_rt, ifid_rs, ifid_rt,
           exmem_pc_src, dmem_req, dmem_ready, imem_ready,
    output stall_pc, stall_ifid, stall_idex, stall_exmem,
           flush_ifid, flush_idex, flush_exmem, flush_memwb,
           ctrl_state, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Merges data-memory wait,
// taken branch, fetch wait and load-use hazards into per-register hold and
// bubble enables, and watches data-memory waits with a saturating watchdog.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input logic clock,
  input logic reset,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_events
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_ERR   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic dstall;
  logic lu;
  logic istall;
  logic branch_taken;

  assign dstall = hz.dmem_req & ~hz.dmem_ready;
  assign lu     = hz.idex_mem_read & (hz.idex_rt != 5'd0) &
                  ((hz.idex_rt == hz.ifid_rs) | (hz.idex_rt == hz.ifid_rt));
  assign istall = ~hz.imem_ready;

  assign hz.ctrl_state  = state_q;
  assign hz.mem_timeout = timeout_q;

  // Resolve hazards in strict priority: reset bubbles, data wait, branch, fetch wait, load-use.
  always_comb begin
    hz.stall_pc    = 1'b0;
    hz.stall_ifid  = 1'b0;
    hz.stall_idex  = 1'b0;
    hz.stall_exmem = 1'b0;
    hz.flush_ifid  = 1'b0;
    hz.flush_idex  = 1'b0;
    hz.flush_exmem = 1'b0;
    hz.flush_memwb = 1'b0;
    branch_taken   = 1'b0;
    if (reset) begin
      hz.flush_ifid  = 1'b1;
      hz.flush_idex  = 1'b1;
      hz.flush_exmem = 1'b1;
      hz.flush_memwb = 1'b1;
    end else if (dstall) begin
      hz.stall_pc    = 1'b1;
      hz.stall_ifid  = 1'b1;
      hz.stall_idex  = 1'b1;
      hz.stall_exmem = 1'b1;
      hz.flush_memwb = 1'b1;
    end else if (hz.exmem_pc_src) begin
      hz.flush_ifid  = 1'b1;
      hz.flush_idex  = 1'b1;
      hz.flush_exmem = 1'b1;
      branch_taken   = 1'b1;
    end else if (istall) begin
      hz.stall_pc    = 1'b1;
      hz.flush_ifid  = 1'b1;
    end else if (lu) begin
      hz.stall_pc    = 1'b1;
      hz.stall_ifid  = 1'b1;
      hz.flush_idex  = 1'b1;
    end
  end

  // Data-wait tracker: counts wait cycles, escalates to ERR at the watchdog limit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (dstall) begin
          state_d = ST_DWAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_DWAIT: begin
        if (!dstall) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q >= TIMEOUT_CNT) begin
          state_d   = ST_ERR;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_ERR: begin
        if (!dstall) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State, watchdog counter and sticky timeout flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
  logic [31:0] perf_flush_events_q, perf_flush_events_d;

  // Count PC-hold cycles and accepted branch redirects, wrapping naturally.
  always_comb begin
    perf_stall_cycles_d = perf_stall_cycles_q;
    perf_flush_events_d = perf_flush_events_q;
    if (hz.stall_pc) perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
    if (branch_taken) perf_flush_events_d = perf_flush_events_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_cycles_q <= '0;
      perf_flush_events_q <= '0;
    end else begin
      perf_stall_cycles_q <= perf_stall_cycles_d;
      perf_flush_events_q <= perf_flush_events_d;
    end
  end

  assign perf_stall_cycles = perf_stall_cycles_q;
  assign perf_flush_events = perf_flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. The driver applies inputs just
// after each rising edge and pushes the expected response; the monitor pops
// and compares on the falling edge. The reference model tracks the length of
// the current data-wait run and a sticky timeout bit.
module tb_pipeline_hazard_ctrl;
  localparam int T = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if hz();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_events;
`endif

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
    .clock(clock),
    .reset(reset),
    .hz(hz)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_events(perf_flush_events)
`endif
  );

  typedef struct {
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic [1:0]  state;
    logic        timeout;
    logic [31:0] pstall;
    logic [31:0] pflush;
  } exp_t;

  exp_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  int          wait_run  = 0;
  bit          timed_out = 1'b0;
  logic [31:0] m_pstall  = '0;
  logic [31:0] m_pflush  = '0;

  // rst_mode: 0 = normal cycle, 1 = reset held across the cycle, 2 = short async pulse mid-cycle
  task automatic applyStimulus(input bit mr, input logic [4:0] ert, input logic [4:0] drs,
                               input logic [4:0] drt, input bit pcsrc, input bit dreq,
                               input bit drdy, input bit irdy, input int rst_mode);
    exp_t e;
    bit dstall, lu, branch;
    @(posedge clock);
    #1;
    hz.idex_mem_read = mr;
    hz.idex_rt       = ert;
    hz.ifid_rs       = drs;
    hz.ifid_rt       = drt;
    hz.exmem_pc_src  = pcsrc;
    hz.dmem_req      = dreq;
    hz.dmem_ready    = drdy;
    hz.imem_ready    = irdy;
    reset            = (rst_mode == 1);
    if (rst_mode == 2) begin
      #1 reset = 1'b1;
      #1 reset = 1'b0;
    end
    if (rst_mode != 0) begin
      wait_run  = 0;
      timed_out = 1'b0;
      m_pstall  = '0;
      m_pflush  = '0;
    end
    dstall = dreq && !drdy;
    lu     = mr && (ert != 5'd0) && (ert == drs || ert == drt);
    branch = 1'b0;
    e.state   = (wait_run == 0) ? 2'd0 : ((wait_run <= T) ? 2'd1 : 2'd2);
    e.timeout = timed_out;
    e.pstall  = m_pstall;
    e.pflush  = m_pflush;
    if (rst_mode == 1) begin
      e.stall = 4'b0000; e.flush = 4'b1111;
    end else if (dstall) begin
      e.stall = 4'b1111; e.flush = 4'b0001;
    end else if (pcsrc) begin
      e.stall = 4'b0000; e.flush = 4'b1110; branch = 1'b1;
    end else if (!irdy) begin
      e.stall = 4'b1000; e.flush = 4'b1000;
    end else if (lu) begin
      e.stall = 4'b1100; e.flush = 4'b0100;
    end else begin
      e.stall = 4'b0000; e.flush = 4'b0000;
    end
    exp_q.push_back(e);
    if (rst_mode != 1) begin
      if (dstall) begin
        if (wait_run < T + 2) wait_run++;
      end else begin
        wait_run = 0;
      end
      if (wait_run > T) timed_out = 1'b1;
      if (e.stall[3]) m_pstall = m_pstall + 32'd1;
      if (branch) m_pflush = m_pflush + 32'd1;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [3:0] got_stall, got_flush;
    got_stall = {hz.stall_pc, hz.stall_ifid, hz.stall_idex, hz.stall_exmem};
    got_flush = {hz.flush_ifid, hz.flush_idex, hz.flush_exmem, hz.flush_memwb};
    tests_run++;
    if (got_stall !== e.stall || got_flush !== e.flush) begin
      tests_failed++;
      $display("[TB] FAIL stall_flush @%0t: got stall=%b flush=%b, expected stall=%b flush=%b",
               $time, got_stall, got_flush, e.stall, e.flush);
    end
    tests_run++;
    if (hz.ctrl_state !== e.state) begin
      tests_failed++;
      $display("[TB] FAIL ctrl_state @%0t: got %0d, expected %0d", $time, hz.ctrl_state, e.state);
    end
    tests_run++;
    if (hz.mem_timeout !== e.timeout) begin
      tests_failed++;
      $display("[TB] FAIL mem_timeout @%0t: got %b, expected %b", $time, hz.mem_timeout, e.timeout);
    end
`ifdef HAZARD_PERF_EN
    tests_run++;
    if (perf_stall_cycles !== e.pstall || perf_flush_events !== e.pflush) begin
      tests_failed++;
      $display("[TB] FAIL perf @%0t: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
               $time, perf_stall_cycles, perf_flush_events, e.pstall, e.pflush);
    end
`endif
  endtask

  // Monitor: every cycle presents a response, compared against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int ready_pct;
    int req_pct;
    int mode;
    hz.idex_mem_read = 1'b0;
    hz.idex_rt       = '0;
    hz.ifid_rs       = '0;
    hz.ifid_rt       = '0;
    hz.exmem_pc_src  = 1'b0;
    hz.dmem_req      = 1'b0;
    hz.dmem_ready    = 1'b0;
    hz.imem_ready    = 1'b1;
    ready_pct        = 50;
    req_pct          = 50;

    $display("[TB] directed sequences");
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // load-use bubble then clear
    applyStimulus(1, 5, 5, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 5, 5, 0, 0, 0, 0, 1, 0);
    // rt = 0 guard
    applyStimulus(1, 0, 3, 0, 0, 0, 0, 1, 0);
    // three-cycle data wait then release
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // branch frozen under a two-cycle data wait, applied on release
    repeat (2) applyStimulus(0, 0, 0, 0, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // branch beats fetch wait and load-use
    applyStimulus(1, 5, 5, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // watchdog escalation, sticky flag, async clear by a mid-cycle pulse
    repeat (8) applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // reset held in the middle of a data wait
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0);

    $display("[TB] randomized sequences");
    for (int i = 0; i < 1500; i++) begin
      if (i % 16 == 0) begin
        case ($urandom_range(0, 2))
          0: ready_pct = 3;
          1: ready_pct = 40;
          default: ready_pct = 85;
        endcase
        req_pct = ($urandom_range(0, 1) == 0) ? 90 : 35;
      end
      mode = 0;
      if ($urandom_range(0, 199) == 0) mode = 1;
      else if ($urandom_range(0, 149) == 0) mode = 2;
      applyStimulus($urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    $urandom_range(0, 9) < 2,
                    $urandom_range(0, 99) < req_pct,
                    $urandom_range(0, 99) < ready_pct,
                    $urandom_range(0, 9) > 1,
                    mode);
    end

    @(negedge clock);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
